// File: rtl/fma_special_result_encoder.sv
// Special-value result encoder for R = A*B + C: 2-stage valid/ready pipeline producing NaN/Inf/signed-zero words and NV.
// Optional denormals-are-zero operand handling is compiled in with FMA_SRE_DAZ_EN.
module fma_special_result_encoder #(
  parameter int unsigned PARM_XLEN   = 32,
  parameter int unsigned PARM_EXP    = 8,
  parameter int unsigned PARM_MANT   = 23,
  parameter logic [2:0]  PARM_RM_RDN = 3'b010
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           rm_i,
  input  logic                 A_Sign_i,
  input  logic                 B_Sign_i,
  input  logic                 C_Sign_i,
  input  logic                 A_Inf_i,
  input  logic                 B_Inf_i,
  input  logic                 C_Inf_i,
  input  logic                 A_Zero_i,
  input  logic                 B_Zero_i,
  input  logic                 C_Zero_i,
  input  logic                 A_NaN_i,
  input  logic                 B_NaN_i,
  input  logic                 C_NaN_i,
  input  logic                 A_SNaN_i,
  input  logic                 B_SNaN_i,
  input  logic                 C_SNaN_i,
  input  logic                 A_DeN_i,
  input  logic                 B_DeN_i,
  input  logic                 C_DeN_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 Special_o,
  output logic [PARM_XLEN-1:0] Result_o,
  output logic                 NV_o
);

  localparam int unsigned EXP_W  = PARM_EXP;
  localparam int unsigned MANT_W = PARM_MANT;

  localparam logic [PARM_XLEN-1:0] CANON_NAN =
    PARM_XLEN'({1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}});

  typedef struct packed {
    logic       ps;
    logic       p_inf;
    logic       p_zero;
    logic       any_nan;
    logic       any_snan;
    logic       inv_mul;
    logic       c_sign;
    logic       c_inf;
    logic       c_zero;
    logic [2:0] rm;
  } s1_t;

  function automatic logic [PARM_XLEN-1:0] inf_word(input logic sign);
    return PARM_XLEN'({sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}});
  endfunction

  function automatic logic [PARM_XLEN-1:0] zero_word(input logic sign);
    return PARM_XLEN'({sign, {(PARM_XLEN-1){1'b0}}});
  endfunction

  logic a_zero_raw, b_zero_raw, c_zero_raw;

`ifdef FMA_SRE_DAZ_EN
  assign a_zero_raw = A_Zero_i | A_DeN_i;
  assign b_zero_raw = B_Zero_i | B_DeN_i;
  assign c_zero_raw = C_Zero_i | C_DeN_i;
`else
  assign a_zero_raw = A_Zero_i;
  assign b_zero_raw = B_Zero_i;
  assign c_zero_raw = C_Zero_i;
  logic unused_den;
  assign unused_den = A_DeN_i ^ B_DeN_i ^ C_DeN_i;
`endif

  // A NaN flag on an operand suppresses any Inf/Zero flag raised alongside it.
  logic a_inf, b_inf, c_inf, a_zero, b_zero, c_zero;
  assign a_inf  = A_Inf_i & ~A_NaN_i;
  assign b_inf  = B_Inf_i & ~B_NaN_i;
  assign c_inf  = C_Inf_i & ~C_NaN_i;
  assign a_zero = a_zero_raw & ~A_NaN_i;
  assign b_zero = b_zero_raw & ~B_NaN_i;
  assign c_zero = c_zero_raw & ~C_NaN_i;

  s1_t s1_d, s1_q;
  logic s1_valid;

  always_comb begin : decode
    s1_d          = '0;
    s1_d.ps       = A_Sign_i ^ B_Sign_i;
    s1_d.p_inf    = a_inf | b_inf;
    s1_d.p_zero   = a_zero | b_zero;
    s1_d.any_nan  = A_NaN_i | B_NaN_i | C_NaN_i;
    s1_d.any_snan = (A_NaN_i & A_SNaN_i) | (B_NaN_i & B_SNaN_i) | (C_NaN_i & C_SNaN_i);
    s1_d.inv_mul  = (a_inf & b_zero) | (a_zero & b_inf);
    s1_d.c_sign   = C_Sign_i;
    s1_d.c_inf    = c_inf;
    s1_d.c_zero   = c_zero;
    s1_d.rm       = rm_i;
  end

  logic                 special_c;
  logic [PARM_XLEN-1:0] result_c;
  logic                 nv_c;

  // Priority-ordered special-case resolution; first match wins.
  always_comb begin : resolve
    special_c = 1'b1;
    result_c  = CANON_NAN;
    nv_c      = 1'b0;
    if (s1_q.any_nan) begin
      nv_c = s1_q.any_snan | s1_q.inv_mul;
    end else if (s1_q.inv_mul) begin
      nv_c = 1'b1;
    end else if (s1_q.p_inf && s1_q.c_inf && (s1_q.ps != s1_q.c_sign)) begin
      nv_c = 1'b1;
    end else if (s1_q.p_inf) begin
      result_c = inf_word(s1_q.ps);
    end else if (s1_q.c_inf) begin
      result_c = inf_word(s1_q.c_sign);
    end else if (s1_q.p_zero && s1_q.c_zero) begin
      result_c = zero_word((s1_q.ps == s1_q.c_sign) ? s1_q.ps : (s1_q.rm == PARM_RM_RDN));
    end else begin
      special_c = 1'b0;
      result_c  = '0;
    end
  end

  logic s2_load;
  assign s2_load = ~valid_o | ready_i;
  assign ready_o = ~valid_o | ready_i | ~s1_valid;

  always_ff @(posedge clk_i) begin : pipe
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      valid_o   <= 1'b0;
      Special_o <= 1'b0;
      Result_o  <= '0;
      NV_o      <= 1'b0;
    end else begin
      if (ready_o) begin
        s1_valid <= valid_i;
        s1_q     <= s1_d;
      end
      // Bubbles leave zeroed outputs behind them.
      if (s2_load) begin
        valid_o   <= s1_valid;
        Special_o <= s1_valid & special_c;
        Result_o  <= s1_valid ? result_c : '0;
        NV_o      <= s1_valid & nv_c;
      end
    end
  end

endmodule

// File: tb/tb_fma_special_result_encoder.sv
// Directed self-checking bench for fma_special_result_encoder; expectations adapt to FMA_SRE_DAZ_EN.
module tb_fma_special_result_encoder;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, ready_i;
  logic [2:0]  rm_i;
  logic        A_Sign_i, B_Sign_i, C_Sign_i, A_Inf_i, B_Inf_i, C_Inf_i;
  logic        A_Zero_i, B_Zero_i, C_Zero_i, A_NaN_i, B_NaN_i, C_NaN_i;
  logic        A_SNaN_i, B_SNaN_i, C_SNaN_i, A_DeN_i, B_DeN_i, C_DeN_i;
  logic        valid_o, Special_o, NV_o;
  logic [31:0] Result_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fma_special_result_encoder dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .rm_i(rm_i),
    .A_Sign_i(A_Sign_i), .B_Sign_i(B_Sign_i), .C_Sign_i(C_Sign_i),
    .A_Inf_i(A_Inf_i), .B_Inf_i(B_Inf_i), .C_Inf_i(C_Inf_i),
    .A_Zero_i(A_Zero_i), .B_Zero_i(B_Zero_i), .C_Zero_i(C_Zero_i),
    .A_NaN_i(A_NaN_i), .B_NaN_i(B_NaN_i), .C_NaN_i(C_NaN_i),
    .A_SNaN_i(A_SNaN_i), .B_SNaN_i(B_SNaN_i), .C_SNaN_i(C_SNaN_i),
    .A_DeN_i(A_DeN_i), .B_DeN_i(B_DeN_i), .C_DeN_i(C_DeN_i),
    .valid_o(valid_o), .ready_i(ready_i), .Special_o(Special_o),
    .Result_o(Result_o), .NV_o(NV_o)
  );

  // Operand code: {sign, inf, zero, nan, snan, den}
  localparam logic [5:0] P_NORM = 6'b000000, N_NORM = 6'b100000;
  localparam logic [5:0] P_INF  = 6'b010000, N_INF  = 6'b110000;
  localparam logic [5:0] P_ZERO = 6'b001000, N_ZERO = 6'b101000;
  localparam logic [5:0] QNAN   = 6'b000100, SNAN   = 6'b000110;
  localparam logic [5:0] P_DEN  = 6'b000001, INF_NAN = 6'b010100;
  localparam logic [5:0] SNAN_ONLY = 6'b000010;
  localparam logic [2:0] RNE = 3'b000, RDN = 3'b010;

  typedef struct packed {
    logic [5:0]  a, b, c;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        sp, nv;
  } vec_t;

  task automatic set_ops(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                         input logic [2:0] rm);
    {A_Sign_i, A_Inf_i, A_Zero_i, A_NaN_i, A_SNaN_i, A_DeN_i} = a;
    {B_Sign_i, B_Inf_i, B_Zero_i, B_NaN_i, B_SNaN_i, B_DeN_i} = b;
    {C_Sign_i, C_Inf_i, C_Zero_i, C_NaN_i, C_SNaN_i, C_DeN_i} = c;
    rm_i = rm;
  endtask

  // Sends one beat into an idle pipeline and returns the first valid output and its latency.
  task automatic run_beat(input vec_t v, output logic [31:0] res, output logic sp,
                          output logic nv, output int lat);
    set_ops(v.a, v.b, v.c, v.rm);
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    res = Result_o;
    sp  = Special_o;
    nv  = NV_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    set_ops(SNAN, P_NORM, P_NORM, RNE);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, valid_o); end
      checks++;
      if (Result_o !== 32'h0) begin errors++; $display("FAIL reset_result cyc%0d got %h exp 0", i, Result_o); end
      checks++;
      if (NV_o !== 1'b0) begin errors++; $display("FAIL reset_nv cyc%0d got %b exp 0", i, NV_o); end
    end
    rst_i   = 1'b0;
    valid_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b exp 0", valid_o); end
  endtask

  task automatic test_specials();
    vec_t v[16];
    logic [31:0] res;
    logic sp, nv;
    int lat;
    v[0]  = '{SNAN,   P_NORM, P_NORM, RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[1]  = '{QNAN,   P_NORM, P_NORM, RNE, 32'h7FC00000, 1'b1, 1'b0};
    v[2]  = '{P_INF,  P_ZERO, QNAN,   RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[3]  = '{N_INF,  P_NORM, P_INF,  RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[4]  = '{N_INF,  N_NORM, P_NORM, RNE, 32'h7F800000, 1'b1, 1'b0};
    v[5]  = '{P_ZERO, N_NORM, P_ZERO, RNE, 32'h00000000, 1'b1, 1'b0};
    v[6]  = '{P_ZERO, N_NORM, P_ZERO, RDN, 32'h80000000, 1'b1, 1'b0};
    v[7]  = '{N_ZERO, P_NORM, N_ZERO, RNE, 32'h80000000, 1'b1, 1'b0};
    v[8]  = '{P_NORM, P_NORM, P_NORM, RNE, 32'h00000000, 1'b0, 1'b0};
    v[9]  = '{P_NORM, P_NORM, N_INF,  RNE, 32'hFF800000, 1'b1, 1'b0};
    v[10] = '{P_ZERO, P_INF,  P_NORM, RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[11] = '{INF_NAN, P_ZERO, P_NORM, RNE, 32'h7FC00000, 1'b1, 1'b0};
    v[12] = '{P_NORM, P_NORM, SNAN,   RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[13] = '{SNAN_ONLY, P_NORM, P_NORM, RNE, 32'h00000000, 1'b0, 1'b0};
`ifdef FMA_SRE_DAZ_EN
    v[14] = '{P_DEN,  P_INF,  P_NORM, RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[15] = '{P_DEN,  N_NORM, P_ZERO, RDN, 32'h80000000, 1'b1, 1'b0};
`else
    v[14] = '{P_DEN,  P_INF,  P_NORM, RNE, 32'h7F800000, 1'b1, 1'b0};
    v[15] = '{P_DEN,  N_NORM, P_ZERO, RDN, 32'h00000000, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 16; i++) begin
      run_beat(v[i], res, sp, nv, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL vec%0d_latency got %0d exp 2", i, lat); end
      checks++;
      if (res !== v[i].res) begin errors++; $display("FAIL vec%0d_result got %h exp %h", i, res, v[i].res); end
      checks++;
      if (sp !== v[i].sp) begin errors++; $display("FAIL vec%0d_special got %b exp %b", i, sp, v[i].sp); end
      checks++;
      if (nv !== v[i].nv) begin errors++; $display("FAIL vec%0d_nv got %b exp %b", i, nv, v[i].nv); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[5];
    logic rdy_pat[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic saw_ready_low = 1'b0;
    v[0] = '{SNAN,   P_NORM, P_NORM, RNE, 32'h7FC00000, 1'b1, 1'b1};
    v[1] = '{N_INF,  N_NORM, P_NORM, RNE, 32'h7F800000, 1'b1, 1'b0};
    v[2] = '{P_ZERO, N_NORM, P_ZERO, RDN, 32'h80000000, 1'b1, 1'b0};
    v[3] = '{P_NORM, P_NORM, P_NORM, RNE, 32'h00000000, 1'b0, 1'b0};
    v[4] = '{P_NORM, P_NORM, N_INF,  RNE, 32'hFF800000, 1'b1, 1'b0};
    while (out_idx < 5 && cyc < 40) begin
      ready_i = (cyc < 12) ? rdy_pat[cyc] : 1'b1;
      if (in_idx < 5) begin
        set_ops(v[in_idx].a, v[in_idx].b, v[in_idx].c, v[in_idx].rm);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (!ready_o) saw_ready_low = 1'b1;
      // A valid output, stalled or not, must always show the oldest undelivered beat.
      if (valid_o) begin
        checks++;
        if (Result_o !== v[out_idx].res || Special_o !== v[out_idx].sp || NV_o !== v[out_idx].nv) begin
          errors++;
          $display("FAIL b2b_beat%0d cyc%0d got res=%h sp=%b nv=%b exp res=%h sp=%b nv=%b", out_idx, cyc,
                   Result_o, Special_o, NV_o, v[out_idx].res, v[out_idx].sp, v[out_idx].nv);
        end
        if (ready_i) out_idx++;
      end
      if (valid_i && ready_o) in_idx++;
      @(posedge clk); #1;
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    checks++;
    if (out_idx !== 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", out_idx); end
    checks++;
    if (saw_ready_low !== 1'b1) begin errors++; $display("FAIL b2b_backpressure got %b exp 1", saw_ready_low); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate got %b exp 0", valid_o); end
  endtask

  task automatic test_reset_midflight();
    set_ops(SNAN, P_NORM, P_NORM, RNE);
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    rst_i   = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_o !== 1'b0 || NV_o !== 1'b0 || Result_o !== 32'h0) begin
        errors++;
        $display("FAIL midreset_flush cyc%0d got valid=%b nv=%b res=%h exp 0/0/0", i, valid_o, NV_o, Result_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fma_special_result_encoder.md
Name: fma_special_result_encoder

Overview:
- Output-side counterpart of the FMA input special-case classifier. It consumes per-operand class flags and signs for R = A*B + C.
- It decides whether R is an IEEE-754 special value (NaN, Inf or signed zero) and encodes the final packed result word plus the invalid flag.
- It is a 2-stage valid/ready pipeline alongside the MAC datapath. The downstream result mux selects Result_o whenever Special_o is set.

Parameters:
- PARM_XLEN, 32, packed word width
- PARM_EXP, 8, exponent field width
- PARM_MANT, 23, stored mantissa width
- PARM_RM_RDN, 3'b010, rounding-mode encoding for round-down

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- ready_o  out  1  block can accept a beat
- rm_i  in  3  rounding mode
- A_Sign_i, B_Sign_i, C_Sign_i  in  1 each  operand signs
- A_Inf_i, B_Inf_i, C_Inf_i  in  1 each  operand is infinity
- A_Zero_i, B_Zero_i, C_Zero_i  in  1 each  operand is zero
- A_NaN_i, B_NaN_i, C_NaN_i  in  1 each  operand is NaN (any kind)
- A_SNaN_i, B_SNaN_i, C_SNaN_i  in  1 each  operand is signalling NaN; only meaningful when the matching NaN flag is set
- A_DeN_i, B_DeN_i, C_DeN_i  in  1 each  operand is subnormal
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts
- Special_o  out  1  R is fully determined here
- Result_o  out  PARM_XLEN  encoded special result; all zeros when Special_o=0
- NV_o  out  1  invalid-operation flag

Behaviour:
- Reset: the synchronous, active-high rst_i clears both stage-valid bits and sets valid_o, Special_o, Result_o and NV_o to 0. ready_o is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats; no partial output appears.
- Handshake:
  - An input beat transfers when valid_i && ready_o. An output beat transfers when valid_o && ready_i.
  - ready_o = !s2_valid || ready_i || !s1_valid, so either stage advances when the stage ahead is empty or draining.
  - While valid_o=1 and ready_i=0, all outputs are held stable.
  - No beat is dropped or duplicated.
- Latency: exactly 2 cycles from input transfer to valid_o when ready_i stays high. Throughput is 1 beat per cycle.
- Stage 1 registers the decoded terms:
  - Ps = A_Sign^B_Sign
  - PInf = (A_Inf|B_Inf)
  - PZero = (A_Zero|B_Zero)
  - anyNaN, anySNaN
  - invMul = (A_Inf&B_Zero)|(A_Zero&B_Inf)
  - rm
- Stage 2 applies the following rules in priority order; the first match wins:
  1. anyNaN: Special=1, Result=canonical NaN 0x7FC00000 (sign 0, exponent all ones, mantissa MSB 1, rest 0). NV=anySNaN|invMul.
  2. invMul: canonical NaN, NV=1. This includes 0*Inf + qNaN, which is caught by rule 1 with NV=1.
  3. PInf & C_Inf & (Ps != C_Sign): canonical NaN, NV=1.
  4. PInf: {Ps, all-ones exponent, zero mantissa}, NV=0.
  5. C_Inf: {C_Sign, all-ones exponent, zero mantissa}, NV=0.
  6. PZero & C_Zero: signed zero. Sign = Ps if Ps==C_Sign; otherwise sign = (rm==PARM_RM_RDN). NV=0.
  7. Otherwise: Special=0, Result=0, NV=0. The main datapath owns the result.
- Precedence: a NaN flag dominates the Inf and Zero flags if the classifier asserts several for one operand.
- The DeN inputs are ignored unless the optional feature is compiled in.

Optional Feature:
- Macro: FMA_SRE_DAZ_EN.
- Defined: each operand's effective zero = Zero_i | DeN_i in stage 1 (denormals-are-zero), keeping the operand sign. Example: A=+subnormal, B=-1.0, C=+0 gives -0... but because signs differ, sign follows rule 6: +0, or -0 when rm=RDN.
- Undefined: DeN_i pins are unused and subnormals are never special.

Test Plan:
- Reset asserted with valid_i=1 for 3 cycles -> valid_o=0, Result_o=0, NV_o=0 throughout; ready_o=1 the cycle after release.
- A_SNaN=1 (A_NaN=1), B=+1, C=+1, ready_i=1 -> 2 cycles later: valid_o=1, Special_o=1, Result_o=0x7FC00000, NV_o=1. The same with a quiet NaN gives NV_o=0.
- A=+Inf, B=+0, C=qNaN -> 0x7FC00000, NV_o=1. A=-Inf, B=+2, C=+Inf -> 0x7FC00000, NV_o=1. A=-Inf, B=-2, C=+1 -> 0x7F800000, NV_o=0.
- A=+0, B=-3, C=+0, rm=RNE -> 0x00000000. The same with rm=RDN -> 0x80000000. A=-0, B=+1, C=-0 -> 0x80000000.
- Back-to-back beats with ready_i toggling 1,0,0,1 -> outputs held while stalled, ready_o deasserts once both stages are full, and all beats emerge in order with no loss.
- (FMA_SRE_DAZ_EN) A=subnormal, B=+Inf, C=+1 -> 0x7FC00000, NV_o=1. Without the macro -> 0x7F800000, NV_o=0.
